jtframe_rst_seq: RTL and testbench
==================================

JTFRAME_RST_SEQ -- requirements
Module: jtframe_rst_seq

Interface
REQ-001 Parameter LOCK_CYC, default 16: consecutive synchronised PLL-lock cycles required before SDRAM init is requested; minimum 2.
REQ-002 Parameter HOLD_CYC, default 1024: game reset hold length in clk cycles; minimum 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports exactly as follows.
REQ-004 clk  input  1  system clock (clk_sys domain); all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pll_locked  input  1  AND of all PLL lock flags; asynchronous to clk.
REQ-007 sdram_ready  input  1  level from the SDRAM controller, high when initialisation has completed.
REQ-008 downloading  input  1  level, high while ROM download is active.
REQ-009 soft_rst  input  1  single-cycle game reset request from the OSD or keyboard.
REQ-010 game_rst  output  1  active-high game reset, fed to the per-domain reset synchronisers.
REQ-011 sdram_init  output  1  single-cycle request to the SDRAM controller to start initialisation.
REQ-012 st  output  2  current state, for debug: LOCK=0, INIT=1, HOLD=2, RUN=3.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchroniser; "lock" below means the synchronised value.
REQ-014 LOCK state: the filter counter increments each cycle lock=1 and clears to 0 on any cycle lock=0.
REQ-015 LOCK->INIT occurs on the edge that completes LOCK_CYC consecutive lock=1 cycles; sdram_init=1 for exactly that one following cycle.
REQ-016 INIT: wait for sdram_ready=1, then go to HOLD with the hold counter loaded to HOLD_CYC-1.
REQ-017 HOLD: the counter decrements each cycle and saturates at 0.
REQ-018 HOLD->RUN occurs when the counter is 0 and downloading=0; with downloading=0 the block stays in HOLD for exactly HOLD_CYC cycles.
REQ-019 HOLD with counter 0 and downloading=1: remain in HOLD and leave on the first cycle downloading=0.
REQ-020 RUN: soft_rst=1 or downloading=1 causes RUN->HOLD with the counter reloaded to HOLD_CYC-1.
REQ-021 HOLD: soft_rst=1 reloads the counter to HOLD_CYC-1, so the hold is extended.
REQ-022 In INIT, HOLD or RUN, lock=0 causes a transition to LOCK on the next edge and clears the filter counter.
REQ-023 lock=0 has priority over soft_rst, downloading and sdram_ready.
REQ-024 A pll_locked fall SHALL raise game_rst within 3 clk edges: 2 synchroniser edges plus 1 state edge.
REQ-025 game_rst SHALL be registered and equal to (st != RUN) every cycle, with no combinational path from the inputs.
REQ-026 sdram_init SHALL be registered and pulse only on a LOCK->INIT transition; every re-entry into INIT after a lock loss produces a new pulse.
REQ-027 sdram_ready is ignored outside INIT.
REQ-028 soft_rst is ignored in LOCK and INIT.

Reset
REQ-029 rst_n=0 SHALL asynchronously force st=LOCK, game_rst=1, sdram_init=0, both counters=0 and the synchroniser flops=0, regardless of the clock.
REQ-030 Release of rst_n is assumed synchronous to clk by the system.
REQ-031 The first state update after release occurs on the first clk edge with rst_n=1.
REQ-032 Assertion of rst_n mid-operation (any state) SHALL abort immediately to the REQ-029 values; no sdram_init pulse may be emitted during or on exit from reset.

Verification (LOCK_CYC=4, HOLD_CYC=8)
REQ-033 Power-up sequence.
- Stimulus: rst_n released, pll_locked=1, sdram_ready raised 10 cycles after sdram_init.
- Response: one sdram_init pulse; game_rst=1 for exactly 8 cycles after INIT->HOLD; then game_rst=0 and st=3.
REQ-034 Lock filter restart.
- Stimulus: pll_locked dropped for 1 cycle after 3 synchronised high cycles.
- Response: filter restarts; sdram_init asserted only after 4 further consecutive high cycles.
REQ-035 Soft reset in RUN.
- Stimulus: soft_rst pulse in RUN.
- Response: game_rst high for exactly 8 cycles starting next cycle. A second soft_rst on hold cycle 5 extends the hold to 8 cycles after that pulse.
REQ-036 Download hold.
- Stimulus: downloading=1 in RUN for 20 cycles.
- Response: game_rst high throughout; game_rst falls on the cycle after downloading returns to 0.
REQ-037 Lock loss in RUN.
- Stimulus: pll_locked=0 in RUN, then restored.
- Response: game_rst=1 within 3 edges; st=0; a new sdram_init pulse after 4 synchronised lock cycles; the full INIT/HOLD sequence repeats.
REQ-038 Reset mid-hold.
- Stimulus: rst_n=0 asserted in HOLD between clock edges.
- Response: outputs reach REQ-029 values without a clock edge; after release the sequence restarts from LOCK.

Source files
------------

// File: rtl/jtframe_rst_seq.sv
// Power-up / game reset sequencer: filters PLL lock, kicks SDRAM init once per
// lock acquisition, then holds the game in reset for HOLD_CYC cycles.
module jtframe_rst_seq #(
  parameter int LOCK_CYC = 16,
  parameter int HOLD_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sdram_ready,
  input  logic       downloading,
  input  logic       soft_rst,
  output logic       game_rst,
  output logic       sdram_init,
  output logic [1:0] st
);

  localparam int LW = $clog2(LOCK_CYC);
  localparam int HW = $clog2(HOLD_CYC);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_LOCK = 2'd0,
    S_INIT = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          game_rst_q, game_rst_d;
  logic          sdram_init_q, sdram_init_d;
  logic          lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOCK;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      lock_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      game_rst_q   <= 1'b1;
      sdram_init_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      lock_cnt_q   <= lock_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      game_rst_q   <= game_rst_d;
      sdram_init_q <= sdram_init_d;
    end
  end

  always_comb begin
    sync1_d      = pll_locked;
    sync2_d      = sync1_q;
    lock         = sync2_q;
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    sdram_init_d = 1'b0;

    // Losing lock beats every other input, whatever the state.
    if (!lock) begin
      state_d    = S_LOCK;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        S_LOCK: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d      = S_INIT;
            lock_cnt_d   = '0;
            sdram_init_d = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + LW'(1);
          end
        end
        S_INIT: begin
          if (sdram_ready) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (soft_rst) begin
            hold_cnt_d = HOLD_LOAD;
          end else if (hold_cnt_q == '0) begin
            if (!downloading) state_d = S_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q - HW'(1);
          end
        end
        S_RUN: begin
          if (soft_rst || downloading) begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end
        default: state_d = S_LOCK;
      endcase
    end

    // Registered from the next state so game_rst tracks st without lag.
    game_rst_d = (state_d != S_RUN);
  end

  assign game_rst   = game_rst_q;
  assign sdram_init = sdram_init_q;
  assign st         = state_q;

endmodule

// File: tb/tb_jtframe_rst_seq.sv
// Bench for jtframe_rst_seq: directed scenarios plus a random phase, all
// checked against a timestamp-based reference model.
module tb_jtframe_rst_seq;
  localparam int LOCK_CYC = 4;
  localparam int HOLD_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sdram_ready = 1'b0;
  logic       downloading = 1'b0;
  logic       soft_rst = 1'b0;
  logic       game_rst;
  logic       sdram_init;
  logic [1:0] st;

  int errors = 0;
  int checks = 0;
  int n_init = 0;

  // Reference model: lock history, consecutive-lock run, hold start timestamp.
  int m_st;
  bit m_init;
  int m_ones;
  int m_cyc;
  int m_hold_from;
  bit sq[$];

  always #5 clk = ~clk;

  jtframe_rst_seq #(.LOCK_CYC(LOCK_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sdram_ready(sdram_ready),
    .downloading(downloading), .soft_rst(soft_rst), .game_rst(game_rst),
    .sdram_init(sdram_init), .st(st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_init = 0; m_ones = 0; m_cyc = 0; m_hold_from = 0;
    sq.delete();
  endtask

  task automatic model_edge();
    bit lock;
    int nst;
    m_cyc++;
    sq.push_back(pll_locked);
    lock = (sq.size() >= 3) ? sq[sq.size()-3] : 1'b0;
    if (sq.size() > 3) void'(sq.pop_front());
    m_ones = lock ? m_ones + 1 : 0;
    m_init = 0;
    nst = m_st;
    if (!lock) nst = 0;
    else case (m_st)
      0: if (m_ones >= LOCK_CYC) begin nst = 1; m_init = 1; end
      1: if (sdram_ready) begin nst = 2; m_hold_from = m_cyc; end
      2: if (soft_rst) m_hold_from = m_cyc;
         else if (!downloading && (m_cyc - m_hold_from) >= HOLD_CYC) nst = 3;
      default: if (soft_rst || downloading) begin nst = 2; m_hold_from = m_cyc; end
    endcase
    m_st = nst;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("st", st, m_st);
    chk("game_rst", game_rst, (m_st != 3));
    chk("sdram_init", sdram_init, m_init);
    if (sdram_init === 1'b1) n_init++;
    $display("cyc=%0d st=%0d grst=%0b init=%0b pll=%0b rdy=%0b dl=%0b srst=%0b",
             m_cyc, st, game_rst, sdram_init, pll_locked, sdram_ready, downloading, soft_rst);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_st"}, st, 0);
    chk({tag, "_game_rst"}, game_rst, 1);
    chk({tag, "_sdram_init"}, sdram_init, 0);
  endtask

  // Assert rst_n between edges, check without an edge, hold across one edge, release.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("async_rst");
    @(posedge clk);
    #1 check_reset_vals("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_st(input logic [1:0] tgt, input int budget, input string tag);
    int n = 0;
    while (st !== tgt && n < budget) begin tick(); n++; end
    chk(tag, st, tgt);
  endtask

  task automatic wait_init(input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (sdram_init !== 1'b1 && n < budget);
    chk("wait_sdram_init", sdram_init, 1);
  endtask

  // Counts observed HOLD cycles; optional soft_rst during hold cycle pulse_at.
  task automatic measure_hold(input int pulse_at, output int n);
    n = (st === 2'd2) ? 1 : 0;
    while (st === 2'd2 && n < 100) begin
      if (n == pulse_at) soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      if (st === 2'd2) n++;
    end
  endtask

  initial begin
    int n;
    model_reset();
    pll_locked = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("por");
    @(posedge clk);
    #1 check_reset_vals("por_edge");
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up
    n_init = 0;
    wait_init(30, n);
    for (int i = 0; i < 10; i++) tick();
    sdram_ready = 1'b1;
    wait_st(2'd2, 5, "enter_hold");
    sdram_ready = 1'b0;
    measure_hold(0, n);
    chk("powerup_hold_len", n, HOLD_CYC);
    chk("powerup_run", st, 3);
    chk("powerup_init_pulses", n_init, 1);

    // Soft reset in RUN, then extension on hold cycle 5
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    measure_hold(0, n);
    chk("soft_hold_len", n, HOLD_CYC);
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    measure_hold(5, n);
    chk("soft_ext_hold_len", n, 5 + HOLD_CYC);

    // Download hold
    tick();
    downloading = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    downloading = 1'b0;
    tick();
    chk("dl_release_grst", game_rst, 0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("lockloss_grst", game_rst, 1);
    chk("lockloss_st", st, 0);

    // Lock filter restart: 3 synced highs, 1 low, then 4 highs
    pll_locked = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    n_init = 0;
    wait_init(30, n);
    chk("filter_restart_cycles", n, 6);
    chk("filter_restart_pulses", n_init, 1);
    for (int i = 0; i < 3; i++) tick();
    sdram_ready = 1'b1;
    wait_st(2'd3, 30, "relock_run");
    sdram_ready = 1'b0;

    // Reset mid-hold
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    tick(); tick();
    async_reset();
    n_init = 0;
    wait_init(30, n);
    chk("post_rst_init_pulses", n_init, 1);
    sdram_ready = 1'b1;
    wait_st(2'd3, 30, "post_rst_run");
    sdram_ready = 1'b0;

    // Random phase
    for (int i = 0; i < 800; i++) begin
      pll_locked  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      soft_rst    = ($urandom_range(0, 99) < 5);
      sdram_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 4) downloading = ~downloading;
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
